// File: rtl/frame_stream_scanout.sv
// RGB565 stream to HDMI scanout with SCALE x SCALE upscaling.
// A line buffer replays fetched rows; tlast tracks frame alignment.
module frame_stream_scanout #(
  parameter int HRES  = 320,
  parameter int VRES  = 180,
  parameter int SCALE = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_draw_in,
  input  logic        new_frame_in,
  input  logic        pixel_tvalid,
  output logic        pixel_tready,
  input  logic [15:0] pixel_tdata,
  input  logic        pixel_tlast,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        locked_out,
  output logic        tlast_err_out,
  output logic [15:0] underflow_count_out
);

  localparam int NPIX = HRES * VRES;
  localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    STREAM,
    WAIT_LAST
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] src_idx_q, src_idx_d;
  logic          dirty_q, dirty_d;
  logic          tail_q, tail_d;
  logic          err_q, err_d;
  logic [15:0]   uf_q, uf_d;
  logic [15:0]   hold_q, hold_d;
  logic          blank_q, blank_d;
  logic          show_q, show_d;
  logic          use_mem_q, use_mem_d;
  logic [15:0]   mem_q;
  logic [15:0]   linebuf_q [HRES];

  logic [CW-1:0] col;
  logic          fetch_line;
  logic          slot;
  logic          beat;
  logic          wr_en;
  logic [15:0]   pix;

  assign col = CW'(hcount_in / 11'(SCALE));
  assign fetch_line = active_draw_in &&
                      ((vcount_in % 10'(SCALE)) == '0);
  assign slot = fetch_line &&
                ((hcount_in % 11'(SCALE)) == '0);
  assign beat = pixel_tvalid && pixel_tready;

  always_comb begin
    pixel_tready = 1'b0;
    unique case (state_q)
      STREAM:    pixel_tready = slot;
      WAIT_LAST: pixel_tready = 1'b1;
      default:   pixel_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src_idx_d = src_idx_q;
    dirty_d   = dirty_q;
    tail_d    = tail_q;
    err_d     = 1'b0;
    uf_d      = uf_q;
    hold_d    = hold_q;
    blank_d   = blank_q;
    show_d    = 1'b0;
    use_mem_d = 1'b0;
    wr_en     = 1'b0;

    unique case (state_q)
      WAIT_FRAME: begin
        if (new_frame_in) begin
          state_d   = STREAM;
          src_idx_d = '0;
          dirty_d   = 1'b0;
          tail_d    = 1'b0;
        end
      end
      STREAM: begin
        if (new_frame_in) begin
          err_d   = 1'b1;
          state_d = WAIT_LAST;
        end else if (slot) begin
          src_idx_d = src_idx_q + 1'b1;
          if (!pixel_tvalid) begin
            dirty_d = 1'b1;
            if (uf_q != '1) uf_d = uf_q + 16'd1;
          end
          if (src_idx_q == LAST_IDX) begin
            if (beat && pixel_tlast && !dirty_q) begin
              state_d = WAIT_FRAME;
              tail_d  = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_LAST;
            end
          end else if (beat && pixel_tlast) begin
            err_d   = 1'b1;
            state_d = WAIT_FRAME;
          end
        end
      end
      WAIT_LAST: begin
        if (beat && pixel_tlast) state_d = WAIT_FRAME;
      end
      default: state_d = WAIT_FRAME;
    endcase

    if (slot) begin
      blank_d = !(state_q == STREAM && pixel_tvalid);
      wr_en   = !blank_d;
      if (!blank_d) hold_d = pixel_tdata;
    end
    // tail_q keeps a cleanly finished frame visible after its last fetch
    if (fetch_line) begin
      show_d = !blank_d && (state_q == STREAM || tail_q);
    end else if (active_draw_in) begin
      use_mem_d = 1'b1;
      show_d    = (state_q == STREAM) || tail_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= WAIT_FRAME;
      src_idx_q <= '0;
      dirty_q   <= 1'b0;
      tail_q    <= 1'b0;
      err_q     <= 1'b0;
      uf_q      <= '0;
      hold_q    <= '0;
      blank_q   <= 1'b1;
      show_q    <= 1'b0;
      use_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_idx_q <= src_idx_d;
      dirty_q   <= dirty_d;
      tail_q    <= tail_d;
      err_q     <= err_d;
      uf_q      <= uf_d;
      hold_q    <= hold_d;
      blank_q   <= blank_d;
      show_q    <= show_d;
      use_mem_q <= use_mem_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) linebuf_q[col] <= pixel_tdata;
    mem_q <= linebuf_q[col];
  end

  assign pix = use_mem_q ? mem_q : hold_q;
  assign red_out   = show_q ? {pix[15:11], pix[15:13]} : 8'h00;
  assign green_out = show_q ? {pix[10:5], pix[10:9]} : 8'h00;
  assign blue_out  = show_q ? {pix[4:0], pix[4:2]} : 8'h00;

  assign locked_out          = (state_q == STREAM);
  assign tlast_err_out       = err_q;
  assign underflow_count_out = uf_q;

endmodule

// File: tb/tb_frame_stream_scanout.sv
// Scoreboard bench for frame_stream_scanout (HRES=4, VRES=2, SCALE=2).
// A second instance with a long frame exercises counter saturation.
module tb_frame_stream_scanout;

  localparam int S_CLEAN  = 0;
  localparam int S_COLOUR = 1;
  localparam int S_UNDER  = 2;
  localparam int S_EARLY  = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        active_draw_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic        pixel_tvalid = 1'b0;
  logic        pixel_tready;
  logic [15:0] pixel_tdata = '0;
  logic        pixel_tlast = 1'b0;
  logic [7:0]  red_out, green_out, blue_out;
  logic        locked_out, tlast_err_out;
  logic [15:0] underflow_count_out;

  logic        sat_rst = 1'b0;
  logic        sat_act = 1'b0;
  logic        sat_nf = 1'b0;
  logic        sat_tready;
  logic [7:0]  sat_r, sat_g, sat_b;
  logic        sat_locked, sat_err;
  logic [15:0] sat_uf;
  bit          sat_done = 1'b0;

  frame_stream_scanout #(.HRES(4), .VRES(2), .SCALE(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .active_draw_in(active_draw_in), .new_frame_in(new_frame_in),
    .pixel_tvalid(pixel_tvalid), .pixel_tready(pixel_tready),
    .pixel_tdata(pixel_tdata), .pixel_tlast(pixel_tlast),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .locked_out(locked_out), .tlast_err_out(tlast_err_out),
    .underflow_count_out(underflow_count_out)
  );

  frame_stream_scanout #(.HRES(4), .VRES(32768), .SCALE(2)) dut_sat (
    .clk_in(clk_in), .rst_in(sat_rst),
    .hcount_in(11'd0), .vcount_in(10'd0),
    .active_draw_in(sat_act), .new_frame_in(sat_nf),
    .pixel_tvalid(1'b0), .pixel_tready(sat_tready),
    .pixel_tdata(16'h0000), .pixel_tlast(1'b0),
    .red_out(sat_r), .green_out(sat_g), .blue_out(sat_b),
    .locked_out(sat_locked), .tlast_err_out(sat_err),
    .underflow_count_out(sat_uf)
  );

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int err_cnt = 0;
  int slot_no = 0;
  bit acc_prev = 1'b0;

  logic [16:0] src_q [$];
  logic [23:0] sb_q [$];

  logic [15:0] colour_px [8] = '{
    16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
    16'h0000, 16'h8410, 16'h1234, 16'hABCD
  };
  logic [23:0] colour_rgb [8] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
    24'h000000, 24'h848284, 24'h1045A5, 24'hAD796B
  };

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // pixel values 0..7 only touch blue: {i[4:0], i[4:2]}
  function automatic logic [23:0] small_rgb(input int i);
    return {16'h0000, 8'((i << 3) | (i >> 2))};
  endfunction

  function automatic logic [23:0] exp_pixel(input int scn,
                                            input int v,
                                            input int h);
    int i;
    bit fl, odd;
    i = (v / 2) * 4 + h / 2;
    fl = (v % 2) == 0;
    odd = (h % 2) == 1;
    case (scn)
      S_COLOUR: return colour_rgb[i];
      S_UNDER: begin
        if (i == 2) return fl ? 24'h0 : colour_rgb[6];
        if (i >= 4 && !fl) return 24'h0;
        if (i == 7 && odd) return 24'h0;
        return small_rgb(i < 2 ? i : i - 1);
      end
      S_EARLY: begin
        if ((i >= 4 && !fl) || i > 5 || (i == 5 && odd))
          return 24'h0;
        return small_rgb(i);
      end
      default: return small_rgb(i);
    endcase
  endfunction

  task automatic cycle(input int v, input int h, input bit act,
                       input bit nf, input int starve_at);
    logic [16:0] b;
    bit fetch, starve;
    @(negedge clk_in);
    if (acc_prev && src_q.size() > 0) begin
      b = src_q.pop_front();
      acc_cnt++;
    end
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    active_draw_in = act;
    new_frame_in = nf;
    fetch = act && (v % 2 == 0) && (h % 2 == 0);
    starve = fetch && (slot_no == starve_at);
    if (fetch) slot_no++;
    pixel_tvalid = (src_q.size() > 0) && !starve;
    if (src_q.size() > 0) {pixel_tlast, pixel_tdata} = src_q[0];
    else {pixel_tlast, pixel_tdata} = 17'h0;
    #1;
    acc_prev = pixel_tvalid && pixel_tready;
  endtask

  task automatic run_frame(input int scn, input int starve_at,
                           input bit do_rst, input int nb,
                           input int exp_acc, input int exp_err,
                           input int exp_uf);
    int v;
    bit act, rst_hit, rst_chk;
    src_q.delete();
    for (int i = 0; i < nb; i++)
      src_q.push_back({(i == nb - 1),
                       (scn == S_COLOUR) ? colour_px[i] : 16'(i)});
    acc_cnt = 0;
    err_cnt = 0;
    slot_no = 0;
    rst_hit = 1'b0;
    rst_chk = 1'b0;
    for (int ln = 0; ln < 6; ln++) begin
      v = (ln == 0) ? 5 : ln - 1;
      for (int h = 0; h < 12; h++) begin
        act = (v < 4) && (h < 8);
        cycle(v, h, act, (ln == 0) && (h == 0), starve_at);
        if (rst_chk) begin
          check("rst_tready", 32'(pixel_tready), 32'd0);
          check("rst_locked", 32'(locked_out), 32'd0);
          check("rst_uf", 32'(underflow_count_out), 32'd0);
          rst_in = 1'b1;
          rst_chk = 1'b0;
        end
        if (do_rst && v == 1 && h == 3) begin
          rst_in = 1'b0;
          rst_hit = 1'b1;
          rst_chk = 1'b1;
        end
        if (act) sb_q.push_back(rst_hit ? 24'h0 : exp_pixel(scn, v, h));
        if (ln == 1 && h == 0)
          check("lock_start", 32'(locked_out), 32'd1);
      end
    end
    check("lock_end", 32'(locked_out), 32'd0);
    check("beats", 32'(acc_cnt), 32'(exp_acc));
    check("tlast_err", 32'(err_cnt), 32'(exp_err));
    check("uf_count", 32'(underflow_count_out), 32'(exp_uf));
    if (do_rst) src_q.delete();
  endtask

  initial begin
    logic [23:0] want, got;
    forever begin
      @(posedge clk_in);
      #1;
      if (active_draw_in) begin
        got = {red_out, green_out, blue_out};
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_empty v=%0d h=%0d got=%h want=none",
                   vcount_in, hcount_in, got);
        end else begin
          want = sb_q.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL pix v=%0d h=%0d got=%h want=%h",
                     vcount_in, hcount_in, got, want);
          end
        end
      end
      if (tlast_err_out) err_cnt++;
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    sat_rst = 1'b1;
    @(negedge clk_in);
    sat_nf = 1'b1;
    @(negedge clk_in);
    sat_nf = 1'b0;
    sat_act = 1'b1;
    repeat (1000) @(negedge clk_in);
    check("sat_mid", 32'(sat_uf), 32'd1000);
    repeat (69000) @(negedge clk_in);
    sat_act = 1'b0;
    check("sat_full", 32'(sat_uf), 32'hFFFF);
    check("sat_locked", 32'(sat_locked), 32'd1);
    sat_done = 1'b1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_in = 1'b0;
    pixel_tvalid = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
    check("reset_locked", 32'(locked_out), 32'd0);
    check("reset_err", 32'(tlast_err_out), 32'd0);
    check("reset_uf", 32'(underflow_count_out), 32'd0);
    check("reset_tready", 32'(pixel_tready), 32'd0);
    rst_in = 1'b1;
    pixel_tvalid = 1'b0;
    repeat (4) @(negedge clk_in);

    run_frame(S_CLEAN,  -1, 1'b0, 8, 8, 0, 0);
    run_frame(S_COLOUR, -1, 1'b0, 8, 8, 0, 0);
    run_frame(S_UNDER,   2, 1'b0, 8, 8, 1, 1);
    run_frame(S_CLEAN,  -1, 1'b0, 8, 8, 0, 1);
    run_frame(S_EARLY,  -1, 1'b0, 6, 6, 1, 1);
    run_frame(S_CLEAN,  -1, 1'b0, 8, 8, 0, 1);
    run_frame(S_CLEAN,  -1, 1'b1, 8, 4, 0, 0);

    guard = 0;
    while (!sat_done && guard < 200000) begin
      @(negedge clk_in);
      guard++;
    end
    if (!sat_done) check("sat_timeout", 32'd0, 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
